// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RISC-V instruction decode stage with valid/ready output slot
//
// Purpose: decodes the IF/ID instruction, drives register-file read addresses,
// captures the returned operands and registers the decoded fields into a single
// valid/ready output slot towards ID/EX.
//
// Build option: DECODE_SCOREBOARD_EN adds a 32-entry pending-write scoreboard
// that stalls RAW hazards until writeback reports completion. Without it,
// wb_valid/wb_rd are ignored and the stage never interlocks.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          upstream handshake
//   instruction, in_pc         instruction word and its address
//   readReg1/2, readData1/2    register-file read port (async read)
//   wb_valid, wb_rd            writeback completion report
//   flush                      kill the instruction held in the output slot
//   out_valid/out_ready        downstream handshake
//   out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd, out_opcode,
//   out_funct3, out_funct7b5, out_RegWrite, out_illegal   registered decode
module decode_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] in_pc,
  output logic [4:0]        readReg1,
  output logic [4:0]        readReg2,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [4:0]        out_rd,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic              out_funct7b5,
  output logic              out_RegWrite,
  output logic              out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm32;
  logic [DATA_W-1:0] imm_ext;
  logic              writes;
  logic              use_rs1;
  logic              use_rs2;
  logic              illegal;
  logic              reg_write;
  logic              hazard;
  logic              accept;

  assign opcode   = instruction[6:0];
  assign rd       = instruction[11:7];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign readReg1 = rs1;
  assign readReg2 = rs2;

  // Immediates are assembled at 32 bits, then sign-extended once to DATA_W.
  always_comb begin
    imm32   = '0;
    writes  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        writes  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        writes  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{instruction[31]}}, instruction[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        writes = 1'b1;
        imm32  = {instruction[31:12], 12'b0};
      end
      OP_JAL: begin
        writes = 1'b1;
        imm32  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign imm_ext   = DATA_W'($signed(imm32));
  assign reg_write = writes && (rd != 5'd0);
  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] pending;
  logic [31:0] pending_next;
  logic        hazard_rs1;
  logic        hazard_rs2;

  // A writeback landing this cycle is already visible on readData through the
  // register file's write-through, so it does not need to stall.
  assign hazard_rs1 = use_rs1 && (rs1 != 5'd0) && pending[rs1] && !(wb_valid && wb_rd == rs1);
  assign hazard_rs2 = use_rs2 && (rs2 != 5'd0) && pending[rs2] && !(wb_valid && wb_rd == rs2);
  assign hazard     = hazard_rs1 || hazard_rs2;

  // Clears are applied first so a same-cycle set of the same register wins.
  always_comb begin
    pending_next = pending;
    if (wb_valid) pending_next[wb_rd] = 1'b0;
    if (flush && out_valid && out_RegWrite) pending_next[out_rd] = 1'b0;
    if (accept && reg_write) pending_next[rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{wb_valid, wb_rd, use_rs1, use_rs2};
  assign hazard    = 1'b0;
`endif

  // A flush coinciding with an accept still loads the new instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_RegWrite <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_data <= readData1;
      out_rs2_data <= readData2;
      out_imm      <= imm_ext;
      out_rd       <= rd;
      out_opcode   <= opcode;
      out_funct3   <= instruction[14:12];
      out_funct7b5 <= instruction[30];
      out_RegWrite <= reg_write;
      out_illegal  <= illegal;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  readReg1, readReg2;
  logic [31:0] readData1, readData2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_RegWrite, out_illegal;

  decode_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b5(out_funct7b5), .out_RegWrite(out_RegWrite), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Register file with write-through of the same-cycle writeback.
  logic [31:0] rf [32];
  assign readData1 = (readReg1 == 5'd0) ? 32'h0 : (wb_valid && wb_rd == readReg1) ? wb_data : rf[readReg1];
  assign readData2 = (readReg2 == 5'd0) ? 32'h0 : (wb_valid && wb_rd == readReg2) ? wb_data : rf[readReg2];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h0101;
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        rw;
    logic        ill;
    logic        u1;
    logic        u2;
  } dec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: output slot contents plus a list of in-flight writers.
  logic        m_valid;
  dec_t        m_rec;
  logic [31:0] m_pc, m_d1, m_d2;
  int          q[$];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic dec_t mk(input logic [31:0] i, input logic [31:0] imm,
                              input logic rw, input logic ill, input logic u1, input logic u2);
    dec_t d;
    d.instr = i; d.imm = imm; d.rw = rw; d.ill = ill; d.u1 = u1; d.u2 = u2;
    return d;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic wbv,
                                             input logic [4:0] wrd, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
    if (wbv && wrd == a) return wd;
    return rf[a];
  endfunction

  function automatic logic in_q(input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic q_remove(input int v);
    int nq[$];
    foreach (q[i]) if (q[i] != v) nq.push_back(q[i]);
    q = nq;
  endtask

  function automatic logic m_hazard(input dec_t r, input logic wbv, input logic [4:0] wrd);
    int s1, s2;
    s1 = int'(r.instr[19:15]);
    s2 = int'(r.instr[24:20]);
    if (r.u1 && s1 != 0 && in_q(s1) && !(wbv && int'(wrd) == s1)) return 1'b1;
    if (r.u2 && s2 != 0 && in_q(s2) && !(wbv && int'(wrd) == s2)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_out();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_pc", out_pc, m_pc);
    check("out_rs1_data", out_rs1_data, m_d1);
    check("out_rs2_data", out_rs2_data, m_d2);
    check("out_imm", out_imm, m_rec.imm);
    check("out_rd", 32'(out_rd), 32'(m_rec.instr[11:7]));
    check("out_opcode", 32'(out_opcode), 32'(m_rec.instr[6:0]));
    check("out_funct3", 32'(out_funct3), 32'(m_rec.instr[14:12]));
    check("out_funct7b5", 32'(out_funct7b5), 32'(m_rec.instr[30]));
    check("out_RegWrite", 32'(out_RegWrite), 32'(m_rec.rw));
    check("out_illegal", 32'(out_illegal), 32'(m_rec.ill));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_valid = 1'b0; m_rec = '0; m_pc = '0; m_d1 = '0; m_d2 = '0;
    q.delete();
    check_out();
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model, check slot.
  task automatic step(input logic iv, input dec_t r, input logic [31:0] pc, input logic ordy,
                      input logic wbv, input logic [4:0] wrd, input logic [31:0] wd,
                      input logic fl, output logic acc);
    logic        exp_rdy;
    logic [31:0] d1, d2;
    in_valid = iv; instruction = r.instr; in_pc = pc; out_ready = ordy;
    wb_valid = wbv; wb_rd = wrd; wb_data = wd; flush = fl;
    #1;
    exp_rdy = !m_hazard(r, wbv, wrd) && (!m_valid || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (iv) begin
      check("readReg1", 32'(readReg1), 32'(r.instr[19:15]));
      check("readReg2", 32'(readReg2), 32'(r.instr[24:20]));
    end
    acc = iv && exp_rdy;
    d1 = model_read(r.instr[19:15], wbv, wrd, wd);
    d2 = model_read(r.instr[24:20], wbv, wrd, wd);
    @(posedge clk);
    if (wbv) q_remove(int'(wrd));
    if (fl && m_valid && m_rec.rw) q_remove(int'(m_rec.instr[11:7]));
    if (SB && acc && r.rw) q.push_back(int'(r.instr[11:7]));
    if (acc) begin
      m_valid = 1'b1; m_rec = r; m_pc = pc; m_d1 = d1; m_d2 = d2;
    end else if (fl || ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_out();
  endtask

  // Builds a random instruction from chosen fields; the expected immediate is
  // the value that was encoded, not something read back from the bits.
  function automatic dec_t rand_instr();
    dec_t        d;
    int          kind, v;
    logic [31:0] im, w;
    logic [4:0]  rd, s1, s2;
    logic [2:0]  f3;
    logic [6:0]  bad [4];
    bad[0] = 7'h7F; bad[1] = 7'h0F; bad[2] = 7'h73; bad[3] = 7'h2B;
    kind = int'($urandom_range(0, 9));
    rd = 5'($urandom_range(0, 7));
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    im = '0; w = '0;
    d = mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    v = int'($urandom_range(0, 4095)) - 2048;
    case (kind)
      0: begin w = {1'b0, 1'($urandom_range(0, 1)), 5'b0, s2, s1, f3, rd, 7'b0110011}; d.u1 = 1; d.u2 = 1; d.rw = (rd != 0); end
      1, 2, 8: begin
        im = 32'(v);
        w = {im[11:0], s1, f3, rd, (kind == 1) ? 7'b0010011 : (kind == 2) ? 7'b0000011 : 7'b1100111};
        d.u1 = 1; d.rw = (rd != 0);
      end
      3: begin im = 32'(v); w = {im[11:5], s2, s1, f3, im[4:0], 7'b0100011}; d.u1 = 1; d.u2 = 1; end
      4: begin im = 32'(v * 2); w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011}; d.u1 = 1; d.u2 = 1; end
      5, 6: begin im = $urandom & 32'hFFFFF000; w = {im[31:12], rd, (kind == 5) ? 7'b0110111 : 7'b0010111}; d.rw = (rd != 0); end
      7: begin
        im = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
        w = {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
        d.rw = (rd != 0);
      end
      default: begin w = $urandom; w[6:0] = bad[$urandom_range(0, 3)]; d.ill = 1; end
    endcase
    d.instr = w; d.imm = im;
    return d;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  dec_t tbl [12];
  dec_t add1, sub4, addi5, lui10, lw7, add8, addi0, addi1, idle;
  logic acc;

  initial begin
    tbl[0]  = mk(32'hFFF00293, 32'hFFFFFFFF, 1, 0, 1, 0);
    tbl[1]  = mk(32'h003100B3, 32'h00000000, 1, 0, 1, 1);
    tbl[2]  = mk(32'h40108233, 32'h00000000, 1, 0, 1, 1);
    tbl[3]  = mk(32'h00100013, 32'h00000001, 0, 0, 1, 0);
    tbl[4]  = mk(32'h00012383, 32'h00000000, 1, 0, 1, 0);
    tbl[5]  = mk(32'h0000007F, 32'h00000000, 0, 1, 0, 0);
    tbl[6]  = mk(32'h12345537, 32'h12345000, 1, 0, 0, 0);
    tbl[7]  = mk(32'hFE512E23, 32'hFFFFFFFC, 0, 0, 1, 1);
    tbl[8]  = mk(32'hFE208CE3, 32'hFFFFFFF8, 0, 0, 1, 1);
    tbl[9]  = mk(32'h001000EF, 32'h00000800, 1, 0, 0, 0);
    tbl[10] = mk(32'h80000197, 32'h80000000, 1, 0, 0, 0);
    tbl[11] = mk(32'h00008067, 32'h00000000, 0, 0, 1, 0);
    addi5 = tbl[0]; add1 = tbl[1]; sub4 = tbl[2]; addi0 = tbl[3]; lw7 = tbl[4]; lui10 = tbl[6];
    add8  = mk(32'h00738433, 32'h0, 1, 0, 1, 1);
    addi1 = mk(32'h00500093, 32'h5, 1, 0, 1, 0);
    idle  = mk(32'h0, 32'h0, 0, 0, 0, 0);

    @(negedge clk);
    do_reset();

    // Decode table: each vector issued from a clean reset.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      step(1, tbl[i], 32'h100 + 32'(i) * 4, 1, 0, 0, 0, 0, acc);
      check("tbl_accept", 32'(in_ready || !acc), 32'h1);
    end

    // RAW interlock released by a same-cycle writeback.
    do_reset();
    step(1, add1, 32'h200, 1, 0, 0, 0, 0, acc);
    step(1, sub4, 32'h204, 1, 0, 0, 0, 0, acc);
    if (!acc) step(1, sub4, 32'h204, 1, 1, 5'd1, 32'hDEADBEEF, 0, acc);
    step(0, idle, 0, 1, 0, 0, 0, 0, acc);

    // Back-pressure: slot held for 3 cycles, then a single transfer.
    do_reset();
    step(1, addi5, 32'h300, 1, 0, 0, 0, 0, acc);
    for (int k = 0; k < 3; k++) step(1, lui10, 32'h304, 0, 0, 0, 0, 0, acc);
    step(0, lui10, 32'h304, 1, 0, 0, 0, 0, acc);
    step(0, idle, 0, 1, 0, 0, 0, 0, acc);

    // Write to x0 sets nothing; a following x0 reader does not stall.
    do_reset();
    step(1, addi0, 32'h400, 1, 0, 0, 0, 0, acc);
    step(1, addi1, 32'h404, 1, 0, 0, 0, 0, acc);

    // Flush of a held load frees x7.
    do_reset();
    step(1, lw7, 32'h500, 1, 0, 0, 0, 0, acc);
    step(0, idle, 0, 0, 0, 0, 0, 1, acc);
    step(1, add8, 32'h508, 1, 0, 0, 0, 0, acc);
    step(0, idle, 0, 1, 0, 0, 0, 0, acc);

    // Reset during a stall empties the scoreboard.
    do_reset();
    step(1, add1, 32'h600, 1, 0, 0, 0, 0, acc);
    step(1, sub4, 32'h604, 1, 0, 0, 0, 0, acc);
    do_reset();
    step(1, sub4, 32'h604, 1, 0, 0, 0, 0, acc);

    // Randomized traffic against the model.
    begin
      dec_t        cur;
      logic        have;
      logic [31:0] cpc;
      logic        ordy, wbv, fl;
      logic [4:0]  wrd;
      do_reset();
      have = 1'b0; cur = idle; cpc = '0;
      for (int c = 0; c < 600; c++) begin
        if (!have && $urandom_range(0, 3) != 0) begin
          cur = rand_instr(); cpc = $urandom; have = 1'b1;
        end
        ordy = ($urandom_range(0, 3) != 0);
        wbv = 1'b0; wrd = '0;
        if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
          wbv = 1'b1; wrd = 5'(q[$urandom_range(0, q.size() - 1)]);
        end else if ($urandom_range(0, 9) == 0) begin
          wbv = 1'b1; wrd = 5'($urandom_range(1, 31));
        end
        fl = !ordy && ($urandom_range(0, 9) == 0);
        step(have, cur, cpc, ordy, wbv, wrd, $urandom, fl, acc);
        if (acc) have = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage between the IF/ID boundary and the ID/EX boundary of the RISC-V datapath. It drives the register file's read addresses from the incoming instruction and captures the returned operands. It also decodes the immediate, destination register and RegWrite, and registers everything into a valid/ready output slot. A 32-entry scoreboard interlocks RAW hazards against in-flight writers until writeback reports completion.

## Interface
- DATA_W, 32, operand/PC width (instruction is always 32 bits)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction present
- in_ready  out  1  stage accepts instruction this cycle
- instruction  in  32  instruction word
- in_pc  in  DATA_W  instruction address
- readReg1, readReg2  out  5  register-file read addresses (combinational from instruction)
- readData1, readData2  in  DATA_W  register-file read data (async read, same cycle)
- wb_valid  in  1  writeback is writing register wb_rd this cycle
- wb_rd  in  5  writeback destination
- flush  in  1  kill the instruction held in the output slot
- out_valid  out  1  output slot holds an instruction
- out_ready  in  1  downstream accepts
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  DATA_W  registered PC, operands, sign-extended immediate
- out_rd  out  5  destination register
- out_opcode  out  7; out_funct3  out  3; out_funct7b5  out  1  registered fields
- out_RegWrite  out  1  instruction writes out_rd
- out_illegal  out  1  unsupported opcode

## Operation
- Supported opcodes: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, lui 0110111, auipc 0010111, jal 1101111, jalr 1100111. Any other opcode sets out_illegal=1 and out_RegWrite=0.
- Immediate per format (I, S, B, U, J), sign-extended from instr[31] to DATA_W. B and J immediates have bit0=0. R-type imm=0.
- Register-field usage: rs1 is used by R/I/load/store/branch/jalr. rs2 is used by R/store/branch.
- out_RegWrite = opcode writes a register AND rd != 0.
- Scoreboard: 32 pending bits, bit 0 hardwired 0.
  - Accept with out_RegWrite: set bit rd.
  - wb_valid: clear bit wb_rd.
  - Same register set and cleared in one cycle: set wins.
- Hazard: a used rs (nonzero) has its pending bit set AND NOT (wb_valid && wb_rd==rs). A same-cycle writeback is visible through the register file's combinational write.
- flush: clears out_valid next cycle and clears the scoreboard bit of the killed instruction's rd, if it had RegWrite. If flush coincides with an accept, the new instruction is still accepted.

## Timing
- in_ready = !hazard && (!out_valid || out_ready).
- Transfer on in_valid && in_ready. Outputs update on the next edge, giving latency 1.
- out_valid && !out_ready: all out_* are held stable.
- out_valid falls after a downstream transfer with no new accept.
- Reset: out_valid=0, all out_* = 0, scoreboard cleared. An instruction held at reset is discarded and is not reported to writeback.
- in_ready may be low with in_valid low. Upstream holds instruction until transfer.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard and hazard interlock as above.
- Undefined: no scoreboard state, hazard forced 0, in_ready = !out_valid || out_ready. wb_valid/wb_rd are ignored and software schedules around RAW hazards.

## Test plan
- Reset, then addi x5,x0,-1 (0xFFF00293) with out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=5, out_RegWrite=1.
- Issue add x1,x2,x3, then sub x4,x1,x1 with no writeback → second instruction stalls (in_ready=0). wb_valid=1, wb_rd=1 → accepted the same cycle with fresh readData1.
- out_ready=0 for 3 cycles with out_valid=1 → outputs unchanged and in_ready=0. Release → one transfer only.
- Write to x0 (addi x0,x0,1) → out_RegWrite=0 and no scoreboard bit set. A following read of x0 does not stall.
- flush on a held lw x7 → out_valid=0 next cycle and bit 7 cleared. A following use of x7 does not stall.
- Illegal opcode 0x0000007F → out_illegal=1, out_RegWrite=0. Reset asserted mid-stall → out_valid=0 and scoreboard empty.
